// File: rtl/shift_seq_arb.sv
// Two-port arbitrated SLL/SRA/ROR shifter, one base-3 stage (x1, x3, x9) per clock.
// Optional macro SHIFT_SEQ_SKIP_EN skips stages whose latched digit is zero.
module shift_seq_arb #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_amt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_amt,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StS1, StS3, StS9, StDone} state_e;

  state_e      state_q;
  logic [15:0] work_q;
  logic [1:0]  op_q, d1_q, d3_q;
  logic        d9_q, id_q, prio_q;

  logic        grant_any, grant_id;
  logic [15:0] acc_data;
  logic [3:0]  acc_amt, a_rem;
  logic [1:0]  acc_op, a_d3, a_d1, a_m;
  logic        a_d9;
  logic [2:0]  a_nz, q_nz;
  logic [4:0]  stage_amt;
  logic [15:0] work_nx;
  state_e      nxt_idle, nxt_run;

  function automatic logic [15:0] stage_shift(input logic [15:0] v, input logic [1:0] op,
                                              input logic [4:0] n);
    logic [31:0] dbl;
    dbl = {v, v} >> n[3:0];
    if (op[1])      return dbl[15:0];
    else if (op[0]) return 16'($signed(v) >>> n);
    else            return v << n;
  endfunction

  // nz[0..2]: digit for x1/x3/x9 is nonzero (forced true when stages are never skipped)
  function automatic state_e next_of(input state_e from, input logic [2:0] nz);
    state_e nx;
    nx = StDone;
    case (from)
      StIdle:  nx = nz[0] ? StS1 : nz[1] ? StS3 : nz[2] ? StS9 : StDone;
      StS1:    nx = nz[1] ? StS3 : nz[2] ? StS9 : StDone;
      StS3:    nx = nz[2] ? StS9 : StDone;
      default: nx = StDone;
    endcase
    return nx;
  endfunction

  always_comb begin
    grant_any  = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = (FIXED_PRIO != 0) ? 1'b0 : prio_q;
    else                          grant_id = req1_valid;
    req0_ready = (state_q == StIdle) & grant_any & ~grant_id;
    req1_ready = (state_q == StIdle) & grant_any & grant_id;

    acc_data = grant_id ? req1_data : req0_data;
    acc_amt  = grant_id ? req1_amt  : req0_amt;
    acc_op   = grant_id ? req1_op   : req0_op;

    // amt = 9*d9 + 3*d3 + d1; d1 fits in two bits so the subtraction is done mod 4
    a_d9  = (acc_amt >= 4'd9);
    a_rem = a_d9 ? acc_amt - 4'd9 : acc_amt;
    a_d3  = (a_rem >= 4'd6) ? 2'd2 : (a_rem >= 4'd3) ? 2'd1 : 2'd0;
    a_m   = (a_d3 == 2'd2) ? 2'd2 : (a_d3 == 2'd1) ? 2'd3 : 2'd0;
    a_d1  = a_rem[1:0] - a_m;

`ifdef SHIFT_SEQ_SKIP_EN
    a_nz = {a_d9, a_d3 != 2'd0, a_d1 != 2'd0};
    q_nz = {d9_q, d3_q != 2'd0, d1_q != 2'd0};
`else
    a_nz = 3'b111;
    q_nz = 3'b111;
`endif
    nxt_idle = next_of(StIdle, a_nz);
    nxt_run  = next_of(state_q, q_nz);

    case (state_q)
      StS1:    stage_amt = {3'b000, d1_q};
      StS3:    stage_amt = (d3_q == 2'd2) ? 5'd6 : (d3_q == 2'd1) ? 5'd3 : 5'd0;
      StS9:    stage_amt = d9_q ? 5'd9 : 5'd0;
      default: stage_amt = 5'd0;
    endcase
    work_nx = stage_shift(work_q, op_q, stage_amt);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      work_q    <= '0;
      op_q      <= '0;
      d1_q      <= '0;
      d3_q      <= '0;
      d9_q      <= 1'b0;
      id_q      <= 1'b0;
      prio_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_any) begin
            work_q  <= acc_data;
            op_q    <= acc_op;
            d1_q    <= a_d1;
            d3_q    <= a_d3;
            d9_q    <= a_d9;
            id_q    <= grant_id;
            prio_q  <= ~grant_id;
            state_q <= nxt_idle;
            if (nxt_idle == StDone) begin
              rsp_valid <= 1'b1;
              rsp_data  <= acc_data;
              rsp_id    <= grant_id;
            end
          end
        end
        StS1, StS3, StS9: begin
          work_q  <= work_nx;
          state_q <= nxt_run;
          if (nxt_run == StDone) begin
            rsp_valid <= 1'b1;
            rsp_data  <= work_nx;
            rsp_id    <= id_q;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_arb.sv
// Scoreboard bench for shift_seq_arb: round-robin instance plus a fixed-priority instance.
module tb_shift_seq_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_data, req1_data, rsp_data;
  logic [3:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, busy;

  logic        v0_f, r0_f, v1_f, r1_f, rsp_valid_f, rsp_id_f, busy_f;
  logic [15:0] rsp_data_f;

  int n_checks = 0;
  int n_errs   = 0;
  logic [16:0] sb[$];  // {id, data}

  always #5 clk = ~clk;

  shift_seq_arb #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  shift_seq_arb #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0_f), .req0_ready(r0_f), .req0_data(16'h0003),
    .req0_amt(4'd1), .req0_op(2'b00),
    .req1_valid(v1_f), .req1_ready(r1_f), .req1_data(16'h00F0),
    .req1_amt(4'd4), .req1_op(2'b10),
    .rsp_valid(rsp_valid_f), .rsp_ready(1'b1), .rsp_data(rsp_data_f), .rsp_id(rsp_id_f),
    .busy(busy_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a,
                                            input logic [1:0] op);
    logic [15:0] r;
    if (op[1]) begin
      for (int i = 0; i < 16; i++) r[i] = d[(i + int'(a)) % 16];
    end else if (op[0]) begin
      r = $signed(d) >>> a;
    end else begin
      r = d << a;
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [3:0] a);
`ifdef SHIFT_SEQ_SKIP_EN
    return 1 + int'(a >= 4'd9) + int'((int'(a) % 9) / 3 != 0) + int'(int'(a) % 3 != 0);
`else
    return 4;
`endif
  endfunction

  task automatic drive(input int port, input logic v, input logic [15:0] d,
                       input logic [3:0] a, input logic [1:0] op);
    if (port == 0) begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_op = op;
    end else begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_op = op;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive a request, wait for its handshake, push the expected response, drop valid.
  task automatic issue(input int port, input logic [15:0] d, input logic [3:0] a,
                       input logic [1:0] op, input bit push);
    bit ok = 0;
    drive(port, 1'b1, d, a, op);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (port == 0) ? req0_ready : req1_ready;
    end
    check_eq("accept", 32'(ok), 32'd1);
    if (ok && push) sb.push_back({1'(port), ref_shift(d, a, op)});
    @(posedge clk); #1;
    drive(port, 1'b0, ~d, ~a, ~op);  // post-accept input changes must be ignored
  endtask

  task automatic finish_op(input logic [3:0] a);
    int lat = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = rsp_valid;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat(a)));
    @(posedge clk); #1;
  endtask

  task automatic run_op(input int port, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] op);
    issue(port, d, a, op, 1'b1);
    finish_op(a);
  endtask

  task automatic accept_both(input int exp_port);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req0_ready | req1_ready;
    end
    check_eq("rr_r0", 32'(req0_ready), 32'(exp_port == 0));
    check_eq("rr_r1", 32'(req1_ready), 32'(exp_port == 1));
    if (exp_port == 0) sb.push_back({1'b0, ref_shift(16'h0003, 4'd1, 2'b00)});
    else               sb.push_back({1'b1, ref_shift(16'h00F0, 4'd4, 2'b10)});
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_rsp", {15'd0, rsp_id, rsp_data}, 32'd0);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        check_eq("rsp_data", 32'(rsp_data), 32'(e[15:0]));
        check_eq("rsp_id", 32'(rsp_id), 32'(e[16]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_bp;
    int bad;
    rst_n = 1'b1;
    req0_valid = 0; req0_data = 0; req0_amt = 0; req0_op = 0;
    req1_valid = 0; req1_data = 0; req1_amt = 0; req1_op = 0;
    rsp_ready = 1'b1; v0_f = 0; v1_f = 0;
    #2;
    do_reset();
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_data", 32'(rsp_data), 32'd0);
    check_eq("rst_id", 32'(rsp_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // directed ops
    run_op(0, 16'h0001, 4'd15, 2'b00);
    run_op(1, 16'h8000, 4'd4,  2'b01);
    run_op(1, 16'h1234, 4'd4,  2'b10);
    run_op(1, 16'h1234, 4'd4,  2'b11);
    run_op(1, 16'h7FFF, 4'd15, 2'b01);
    run_op(0, 16'hA5A5, 4'd0,  2'b00);
    for (int i = 0; i < 24; i++)
      run_op(int'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 2'($urandom));

    // backpressure: hold DONE, other requests must stay unaccepted
    rsp_ready = 1'b0;
    exp_bp = ref_shift(16'h00FF, 4'd3, 2'b10);
    issue(0, 16'h00FF, 4'd3, 2'b10, 1'b1);
    drive(1, 1'b1, 16'h8001, 4'd1, 2'b00);
    bad = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    drive(0, 1'b1, 16'hFFFF, 4'd1, 2'b00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_data", 32'(rsp_data), 32'(exp_bp));
      check_eq("bp_id", 32'(rsp_id), 32'd0);
      check_eq("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check_eq("bp_busy", 32'(busy), 32'd1);
      if (i == 2) #1 drive(0, 1'b0, 16'h0, 4'd0, 2'b00);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("hs_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("next_acc", 32'(req1_ready), 32'd1);
    check_eq("idle_valid", 32'(rsp_valid), 32'd0);
    check_eq("hold_data", 32'(rsp_data), 32'(exp_bp));
    sb.push_back({1'b1, ref_shift(16'h8001, 4'd1, 2'b00)});
    @(posedge clk); #1 drive(1, 1'b0, 16'h0, 4'd0, 2'b00);
    finish_op(4'd1);

    // asynchronous reset in S3 discards the op
    issue(0, 16'h1357, 4'd13, 2'b01, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_data", 32'(rsp_data), 32'd0);
    sb.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) bad++;
    end
    check_eq("no_abort_rsp", 32'(bad), 32'd0);
    @(posedge clk); #1;
    run_op(0, 16'h1357, 4'd13, 2'b01);

    // round robin with both ports valid continuously
    do_reset();
    drive(0, 1'b1, 16'h0003, 4'd1, 2'b00);
    drive(1, 1'b1, 16'h00F0, 4'd4, 2'b10);
    for (int k = 0; k < 4; k++) begin
      accept_both(k % 2);
      finish_op((k % 2 == 0) ? 4'd1 : 4'd4);
    end
    drive(0, 1'b0, 16'h0, 4'd0, 2'b00);
    drive(1, 1'b0, 16'h0, 4'd0, 2'b00);

    // fixed priority: port 0 always wins
    v0_f = 1'b1; v1_f = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = r0_f | r1_f;
      end
      check_eq("fp_r0", 32'(r0_f), 32'd1);
      check_eq("fp_r1", 32'(r1_f), 32'd0);
      @(posedge clk); #1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = rsp_valid_f;
      end
      check_eq("fp_id", 32'(rsp_id_f), 32'd0);
      check_eq("fp_data", 32'(rsp_data_f), 32'(ref_shift(16'h0003, 4'd1, 2'b00)));
      @(posedge clk); #1;
    end
    v0_f = 1'b0; v1_f = 1'b0;

    repeat (3) @(posedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
